// File: rtl/msrv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_pkg
// Description : Shared constants and types for the msrv32 writeback path.
//               Holds the register-file geometry and the writeback port ids.
// Revision    : 1.0 - initial release
// ============================================================================
package msrv32_pkg;

   // Register-file geometry
   localparam int c_XLEN     = 32;
   localparam int c_REG_AW   = 5;
   localparam int c_NUM_REGS = 32;

   // Writeback port indices
   localparam int c_WB_PORT_ALU = 0;
   localparam int c_WB_PORT_LSU = 1;
   localparam int c_WB_PORTS    = 2;

   // Identity of the most recently granted writeback port
   typedef enum logic {
      PORT_ALU = 1'b0,
      PORT_LSU = 1'b1
   } wb_port_e;

   // Register x0 is hard-wired to zero and never written
   function automatic logic is_x0(input logic [c_REG_AW-1:0] addr);
      return (addr == '0);
   endfunction

endpackage : msrv32_pkg
`default_nettype wire

// File: rtl/msrv32_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_rr_arb2
// Description : Two-requester arbiter for the writeback path. Grants are
//               combinational from the current requests and the last-grant
//               register; RR_EN selects round-robin or port-0 priority.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_rr_arb2
   import msrv32_pkg::*;
#(
   parameter int RR_EN = 1
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  hold_in,
   input  logic [c_WB_PORTS-1:0] req_in,
   output logic [c_WB_PORTS-1:0] gnt_out,
   output logic                  gnt_any_out
);

   wb_port_e               r_last;
   logic [c_WB_PORTS-1:0]  w_gnt;
   logic                   w_both;

   assign w_both = req_in[c_WB_PORT_ALU] & req_in[c_WB_PORT_LSU];

   // Grant selection; reset and hold both force an empty grant vector
   generate
      if (RR_EN != 0) begin : g_round_robin
         // The port that did not win last time takes a contested cycle
         always_comb begin
            w_gnt = '0;
            if (rst_n_in && !hold_in) begin
               if (w_both) begin
                  if (r_last == PORT_ALU) begin
                     w_gnt[c_WB_PORT_LSU] = 1'b1;
                  end else begin
                     w_gnt[c_WB_PORT_ALU] = 1'b1;
                  end
               end else begin
                  w_gnt = req_in;
               end
            end
         end
      end else begin : g_fixed_priority
         // Port 0 always takes a contested cycle
         always_comb begin
            w_gnt = '0;
            if (rst_n_in && !hold_in) begin
               if (req_in[c_WB_PORT_ALU]) begin
                  w_gnt[c_WB_PORT_ALU] = 1'b1;
               end else begin
                  w_gnt[c_WB_PORT_LSU] = req_in[c_WB_PORT_LSU];
               end
            end
         end
      end
   endgenerate

   // Remember the winner of every granted cycle; starting at LSU lets ALU win first
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_last <= PORT_LSU;
      end else if (|w_gnt) begin
         r_last <= w_gnt[c_WB_PORT_LSU] ? PORT_LSU : PORT_ALU;
      end
   end

   assign gnt_out     = w_gnt;
   assign gnt_any_out = |w_gnt;

endmodule : msrv32_rr_arb2
`default_nettype wire

// File: rtl/msrv32_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_wb_arbiter
// Description : Writeback arbiter between the ALU and load unit. Selects one
//               request per cycle, registers it onto the integer-file write
//               port, and tracks outstanding destination registers.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_wb_arbiter
   import msrv32_pkg::*;
#(
   parameter int RR_EN = 1
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  hold_in,
   input  logic                  wb0_valid_in,
   input  logic [c_REG_AW-1:0]   wb0_addr_in,
   input  logic [c_XLEN-1:0]     wb0_data_in,
   output logic                  wb0_ready_out,
   input  logic                  wb1_valid_in,
   input  logic [c_REG_AW-1:0]   wb1_addr_in,
   input  logic [c_XLEN-1:0]     wb1_data_in,
   output logic                  wb1_ready_out,
   input  logic                  issue_en_in,
   input  logic [c_REG_AW-1:0]   issue_addr_in,
   output logic                  wr_en_out,
   output logic [c_REG_AW-1:0]   rd_addr_out,
   output logic [c_XLEN-1:0]     rd_out,
   output logic [c_NUM_REGS-1:0] busy_out,
   output logic                  wb_err_out
);

   logic [c_WB_PORTS-1:0]  w_gnt;
   logic                   w_gnt_any;
   logic [c_REG_AW-1:0]    w_sel_addr;
   logic [c_XLEN-1:0]      w_sel_data;
   logic                   w_commit;
   logic [c_NUM_REGS-1:0]  w_busy_nxt;

   logic                   r_wr_en;
   logic [c_REG_AW-1:0]    r_rd_addr;
   logic [c_XLEN-1:0]      r_rd_data;
   logic [c_NUM_REGS-1:0]  r_busy;
   logic                   r_err;

   msrv32_rr_arb2 #(
      .RR_EN       (RR_EN)
   ) u_arb (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .hold_in     (hold_in),
      .req_in      ({wb1_valid_in, wb0_valid_in}),
      .gnt_out     (w_gnt),
      .gnt_any_out (w_gnt_any)
   );

   // Route the winning request; a write to x0 is accepted but goes nowhere
   always_comb begin
      w_sel_addr = wb0_addr_in;
      w_sel_data = wb0_data_in;
      if (w_gnt[c_WB_PORT_LSU]) begin
         w_sel_addr = wb1_addr_in;
         w_sel_data = wb1_data_in;
      end
      w_commit = w_gnt_any && !is_x0(w_sel_addr);
   end

   // Scoreboard update: the committed write clears, an issue sets, and a set wins a tie
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_commit) begin
         w_busy_nxt[w_sel_addr] = 1'b0;
      end
      if (issue_en_in && !is_x0(issue_addr_in)) begin
         w_busy_nxt[issue_addr_in] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Output register, scoreboard and sticky error; reset drops any write in flight
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_wr_en   <= 1'b0;
         r_rd_addr <= '0;
         r_rd_data <= '0;
         r_busy    <= '0;
         r_err     <= 1'b0;
      end else begin
         r_wr_en <= w_commit;
         if (w_commit) begin
            r_rd_addr <= w_sel_addr;
            r_rd_data <= w_sel_data;
         end
         r_busy <= w_busy_nxt;
         if (w_commit && !r_busy[w_sel_addr]) begin
            r_err <= 1'b1;
         end
      end
   end

   assign wb0_ready_out = w_gnt[c_WB_PORT_ALU];
   assign wb1_ready_out = w_gnt[c_WB_PORT_LSU];
   assign wr_en_out     = r_wr_en;
   assign rd_addr_out   = r_rd_addr;
   assign rd_out        = r_rd_data;
   assign busy_out      = r_busy;
   assign wb_err_out    = r_err;

endmodule : msrv32_wb_arbiter
`default_nettype wire

// File: tb/tb_msrv32_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_msrv32_wb_arbiter
// Description : Directed self-checking bench for msrv32_wb_arbiter with a
//               write scoreboard, one round-robin and one fixed-priority DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_wb_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Shared controls
   logic        rst_n, hold;
   // Round-robin instance stimulus and responses
   logic        v0, v1, iss;
   logic [4:0]  a0, a1, ia;
   logic [31:0] d0, d1;
   logic        r0, r1, wr, err;
   logic [4:0]  ra;
   logic [31:0] rd, busy;
   // Fixed-priority instance stimulus and responses
   logic        fv0, fv1;
   logic [4:0]  fa0, fa1;
   logic [31:0] fd0, fd1;
   logic        fr0, fr1, fwr, ferr;
   logic [4:0]  fra;
   logic [31:0] frd, fbusy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   exp_t fq[$];

   // Reference state for the round-robin instance
   logic [31:0] m_busy;
   logic        m_err;
   logic        m_last;

   msrv32_wb_arbiter #(.RR_EN(1)) dut_rr (
      .clk_in(clk), .rst_n_in(rst_n), .hold_in(hold),
      .wb0_valid_in(v0), .wb0_addr_in(a0), .wb0_data_in(d0), .wb0_ready_out(r0),
      .wb1_valid_in(v1), .wb1_addr_in(a1), .wb1_data_in(d1), .wb1_ready_out(r1),
      .issue_en_in(iss), .issue_addr_in(ia),
      .wr_en_out(wr), .rd_addr_out(ra), .rd_out(rd), .busy_out(busy), .wb_err_out(err)
   );

   msrv32_wb_arbiter #(.RR_EN(0)) dut_fp (
      .clk_in(clk), .rst_n_in(rst_n), .hold_in(hold),
      .wb0_valid_in(fv0), .wb0_addr_in(fa0), .wb0_data_in(fd0), .wb0_ready_out(fr0),
      .wb1_valid_in(fv1), .wb1_addr_in(fa1), .wb1_data_in(fd1), .wb1_ready_out(fr1),
      .issue_en_in(1'b0), .issue_addr_in(5'd0),
      .wr_en_out(fwr), .rd_addr_out(fra), .rd_out(frd), .busy_out(fbusy), .wb_err_out(ferr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready0", {31'b0, r0}, 32'd0);
      chk("rst_ready1", {31'b0, r1}, 32'd0);
      chk("rst_wr_en", {31'b0, wr}, 32'd0);
      chk("rst_rd_addr", {27'b0, ra}, 32'd0);
      chk("rst_rd_data", rd, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_fp_wr_en", {31'b0, fwr}, 32'd0);
      chk("rst_fp_ready", {30'b0, fr1, fr0}, 32'd0);
   endtask

   task automatic model_reset();
      m_busy = '0;
      m_err  = 1'b0;
      m_last = 1'b1;
      q.delete();
   endtask

   // Compare the registered outputs against the oldest scoreboard entry
   task automatic check_out();
      exp_t e;
      if (q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_empty observed=%0d expected=1", q.size());
      end else begin
         e = q.pop_front();
         chk("wr_en", {31'b0, wr}, {31'b0, e.wr});
         if (e.wr) begin
            chk("rd_addr", {27'b0, ra}, {27'b0, e.addr});
            chk("rd_data", rd, e.data);
         end
      end
      chk("busy", busy, m_busy);
      chk("wb_err", {31'b0, err}, {31'b0, m_err});
   endtask

   // One clock of round-robin stimulus: drive, check readies, predict, clock, check outputs
   task automatic step(input logic h,
                       input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                       input logic iv1, input logic [4:0] ia1, input logic [31:0] id1,
                       input logic iiss, input logic [4:0] iia);
      exp_t        e;
      logic        g0, g1;
      logic [4:0]  sa;
      logic [31:0] sd;
      hold = h; v0 = iv0; a0 = ia0; d0 = id0; v1 = iv1; a1 = ia1; d1 = id1;
      iss = iiss; ia = iia;
      #1;
      g0 = !h && iv0 && (!iv1 || m_last);
      g1 = !h && iv1 && !g0;
      chk("ready0", {31'b0, r0}, {31'b0, g0});
      chk("ready1", {31'b0, r1}, {31'b0, g1});
      e.wr = 1'b0; e.addr = '0; e.data = '0;
      if (g0 || g1) begin
         sa = g0 ? ia0 : ia1;
         sd = g0 ? id0 : id1;
         m_last = g1;
         if (sa != 5'd0) begin
            e.wr = 1'b1; e.addr = sa; e.data = sd;
            if (!m_busy[sa]) m_err = 1'b1;
            m_busy[sa] = 1'b0;
         end
      end
      if (iiss && iia != 5'd0) m_busy[iia] = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      exp_t fe;
      rst_n = 1'b0; hold = 1'b0;
      v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; iss = 0; ia = 0;
      fv0 = 0; fv1 = 0; fa0 = 0; fa1 = 0; fd0 = 0; fd1 = 0;
      model_reset();
      #2;
      chk_reset_outputs();
      #6;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Issue x5, then the load unit writes it back
      step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5);
      step(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0);

      // Issue x7, then issue x7 again in the cycle its write is granted
      step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
      step(0, 1, 5'd7, 32'h0000_0777, 0, 0, 0, 1, 5'd7);

      // Write to x0 is accepted silently; write to idle x9 raises the sticky error
      step(0, 1, 5'd0, 32'h1234_5678, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 5'd9, 32'h0000_0099, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Both ports contend for four cycles; the loser holds its request
      step(0, 1, 5'd1, 32'hA000_0001, 1, 5'd2, 32'hB000_0002, 0, 0);
      step(0, 1, 5'd3, 32'hA000_0003, 1, 5'd2, 32'hB000_0002, 0, 0);
      step(0, 1, 5'd3, 32'hA000_0003, 1, 5'd4, 32'hB000_0004, 0, 0);
      step(0, 1, 5'd5, 32'hA000_0005, 1, 5'd4, 32'hB000_0004, 0, 0);

      // Hold suppresses grants but still lets issues mark registers busy
      step(1, 1, 5'd6, 32'hC000_0006, 1, 5'd8, 32'hC000_0008, 1, 5'd12);
      step(1, 1, 5'd6, 32'hC000_0006, 1, 5'd8, 32'hC000_0008, 0, 0);
      step(1, 1, 5'd6, 32'hC000_0006, 1, 5'd8, 32'hC000_0008, 0, 0);
      step(0, 1, 5'd6, 32'hC000_0006, 1, 5'd8, 32'hC000_0008, 0, 0);

      // Asynchronous reset while a write is on the output port
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      model_reset();
      v0 = 0; v1 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(0, 1, 5'd10, 32'hE000_000A, 1, 5'd11, 32'hE000_000B, 0, 0);
      step(0, 0, 0, 0, 1, 5'd11, 32'hE000_000B, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Fixed priority: port 0 wins every contested cycle
      for (int i = 0; i < 4; i++) begin
         fv0 = 1; fa0 = 5'(10 + i); fd0 = 32'(i) + 32'h5000_0000;
         fv1 = 1; fa1 = 5'd20;      fd1 = 32'hF000_0014;
         #1;
         chk("fp_ready0", {31'b0, fr0}, 32'd1);
         chk("fp_ready1", {31'b0, fr1}, 32'd0);
         fe.wr = 1'b1; fe.addr = fa0; fe.data = fd0;
         fq.push_back(fe);
         @(posedge clk);
         #1;
         if (fq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL fp_scoreboard_empty observed=%0d expected=1", fq.size());
         end else begin
            fe = fq.pop_front();
            chk("fp_wr_en", {31'b0, fwr}, {31'b0, fe.wr});
            chk("fp_rd_addr", {27'b0, fra}, {27'b0, fe.addr});
            chk("fp_rd_data", frd, fe.data);
         end
      end
      fv0 = 0; fv1 = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute time limit in case the sequence stalls
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_msrv32_wb_arbiter
`default_nettype wire

// File: doc/msrv32_wb_arbiter.md
MSRV32_WB_ARBITER -- requirements
Module: msrv32_wb_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with port 0 winning.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk_in  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous assert, active low.
REQ-005 hold_in  input  1  pipeline hold; while 1, no grant is issued.
REQ-006 wb0_valid_in  input  1  ALU writeback request.
REQ-007 wb0_addr_in  input  5  ALU destination register.
REQ-008 wb0_data_in  input  32  ALU result.
REQ-009 wb0_ready_out  output  1  ALU request accepted this cycle.
REQ-010 wb1_valid_in, wb1_addr_in, wb1_data_in, wb1_ready_out  in/in/in/out  1/5/32/1  load-unit writeback request, with the same meanings as port 0.
REQ-011 issue_en_in  input  1  an instruction with a destination register is issued this cycle.
REQ-012 issue_addr_in  input  5  destination register of the issued instruction.
REQ-013 wr_en_out  output  1  integer-file write enable.
REQ-014 rd_addr_out  output  5  integer-file write address.
REQ-015 rd_out  output  32  integer-file write data.
REQ-016 busy_out  output  32  scoreboard; bit k=1 means a write to xk is outstanding.
REQ-017 wb_err_out  output  1  sticky flag: a write was committed to a register that was not busy.

Function
REQ-018 Grant rule: a grant is issued in a cycle iff hold_in=0 and at least one valid is 1; at most one readyN_out is 1 per cycle, and it is combinational from the current inputs and state.
REQ-019 Single requester valid: that requester SHALL be granted.
REQ-020 Both valid, RR_EN=1: the port not granted most recently SHALL win; the last-grant register resets to 1, so port 0 wins first.
REQ-021 Both valid, RR_EN=0: port 0 SHALL win.
REQ-022 A requester not granted SHALL hold valid, addr and data stable until it is granted; the block does not buffer ungranted requests.
REQ-023 Latency: for a grant in cycle N, wr_en_out=1 with the granted addr/data in cycle N+1; wr_en_out=0 in any cycle following a non-grant cycle.
REQ-024 x0: a granted request with addr=0 SHALL be accepted (ready=1) but SHALL produce wr_en_out=0 and no scoreboard or error effect.
REQ-025 Scoreboard set: issue_en_in=1 with issue_addr_in!=0 SHALL set busy bit [issue_addr_in] at the clock edge.
REQ-026 Scoreboard clear: a grant with addr!=0 SHALL clear busy bit [addr] at the same edge that loads the output register.
REQ-027 Simultaneous set and clear of the same bit: set SHALL win.
REQ-028 busy_out[0] SHALL always read 0.
REQ-029 A grant with addr!=0 whose busy bit is 0 SHALL set wb_err_out, which then stays 1 until reset.
REQ-030 Whenever a grant occurs, the last-grant register SHALL update to the granted port; it is unchanged otherwise.
REQ-031 hold_in=1 SHALL suppress all grants but SHALL NOT block scoreboard sets.

Reset
REQ-032 While rst_n_in=0, and immediately on its assertion (asynchronous, mid-operation included), the block SHALL drive wr_en_out=0, rd_addr_out=0, rd_out=0, busy_out=0, wb_err_out=0, and set last-grant=1.
REQ-033 During reset, wb0_ready_out and wb1_ready_out SHALL be 0.
REQ-034 A write in flight at reset assertion SHALL be dropped.

Structure
REQ-035 The register-address width (5), data width (32) and port indices SHALL be constants in the shared msrv32 package.
REQ-036 Arbitration SHALL be a sub-module, msrv32_rr_arb2, containing the grant logic and the last-grant register; the scoreboard and output register SHALL live in the top module.

Verification
REQ-037 Both ports valid for 4 cycles, RR_EN=1 -> grant order 0,1,0,1; wr_en_out pulses in cycles 2-5 with the matching addresses.
REQ-038 RR_EN=0, both ports valid continuously -> port 0 is granted every cycle and wb1_ready_out stays 0.
REQ-039 Issue x5, then a port-1 write x5=0xDEADBEEF -> busy_out[5] goes 1 then 0; next cycle wr_en_out=1, rd_addr_out=5, rd_out=0xDEADBEEF.
REQ-040 Same-cycle issue x7 and grant of a write to x7 -> busy_out[7] stays 1.
REQ-041 Port-0 write to x0 -> ready=1, wr_en_out=0; a write to non-busy x9 -> wb_err_out=1 and stays 1.
REQ-042 hold_in=1 for 3 cycles with both valid, then reset asserted mid-stream -> no ready during hold; on reset all outputs are 0 and the next grant after release goes to port 0.
